// File: rtl/conv_kernel_arbiter_if.sv
// Bundle between conv_kernel_arbiter and its environment: cfg port, requesters,
// kernel datapath and result consumer. The slave modport is the arbiter's view.
interface conv_kernel_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int KERN_WIDTH = 16,
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int KERN_SIZE  = 3
);
  localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAP_W = ($clog2(KERN_SIZE) > 1) ? $clog2(KERN_SIZE) : 1;

  logic                                           cfg_we;
  logic [ID_W-1:0]                                cfg_id;
  logic [TAP_W-1:0]                               cfg_tap;
  logic [KERN_WIDTH-1:0]                          cfg_coef;
  logic                                           cfg_ack;
  logic                                           cfg_err;

  logic [NUM_REQ-1:0]                             req_vld;
  logic [NUM_REQ-1:0][KERN_SIZE-1:0][DIN_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]                             req_rdy;

  logic [KERN_SIZE-1:0][KERN_WIDTH-1:0]           k_kernel;
  logic                                           k_din_vld;
  logic [KERN_SIZE-1:0][DIN_WIDTH-1:0]            k_din;
  logic                                           k_dout_vld;
  logic [DOUT_WIDTH-1:0]                          k_dout;

  logic                                           res_vld;
  logic                                           res_rdy;
  logic [ID_W-1:0]                                res_id;
  logic [DOUT_WIDTH-1:0]                          res_dout;
  logic                                           err_orphan;

  modport slave (
    input  cfg_we, cfg_id, cfg_tap, cfg_coef,
    input  req_vld, req_din,
    input  k_dout_vld, k_dout,
    input  res_rdy,
    output cfg_ack, cfg_err,
    output req_rdy,
    output k_kernel, k_din_vld, k_din,
    output res_vld, res_id, res_dout, err_orphan
  );

  modport master (
    output cfg_we, cfg_id, cfg_tap, cfg_coef,
    output req_vld, req_din,
    output k_dout_vld, k_dout,
    output res_rdy,
    input  cfg_ack, cfg_err,
    input  req_rdy,
    input  k_kernel, k_din_vld, k_din,
    input  res_vld, res_id, res_dout, err_orphan
  );
endinterface

// File: rtl/conv_kernel_arbiter.sv
// Round-robin sharing of one conv_kernel among NUM_REQ requesters with a credit-protected
// result FIFO. Define CONV_ARB_COEF_LOCK_EN to reject coefficient writes to busy requesters.
module conv_kernel_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int KERN_WIDTH = 16,
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int KERN_SIZE  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  conv_kernel_arbiter_if.slave  bus
);
  localparam int KLAT  = $clog2(KERN_SIZE) + 1;
  localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0][KERN_SIZE-1:0][KERN_WIDTH-1:0] r_bank;
  logic                                       r_cfg_ack;
  logic                                       r_cfg_err;
  logic [ID_W-1:0]                            r_last;
  logic [CNT_W-1:0]                           r_inflight;
  logic [CNT_W-1:0]                           r_occ;
  logic [PTR_W-1:0]                           r_wr_ptr;
  logic [PTR_W-1:0]                           r_rd_ptr;
  logic [ID_W-1:0]                            r_mem_id   [FIFO_DEPTH];
  logic [DOUT_WIDTH-1:0]                      r_mem_dout [FIFO_DEPTH];
  logic                                       r_k_din_vld;
  logic [KERN_SIZE-1:0][DIN_WIDTH-1:0]        r_k_din;
  logic [KERN_SIZE-1:0][KERN_WIDTH-1:0]       r_k_kernel;
  logic [ID_W-1:0]                            r_issue_id;
  logic [KLAT-1:0]                            r_tag_vld;
  logic [ID_W-1:0]                            r_tag_id [KLAT];
  logic                                       r_err_orphan;

  logic [CNT_W:0]                             w_credit_sum;
  logic                                       w_credit_ok;
  logic [NUM_REQ-1:0]                         w_grant;
  logic [ID_W-1:0]                            w_gnt_id;
  logic                                       w_accept;
  logic                                       w_tail_vld;
  logic [ID_W-1:0]                            w_tail_id;
  logic                                       w_push;
  logic                                       w_pop;
  logic                                       w_res_vld;
  logic                                       w_cfg_in_range;
  logic                                       w_cfg_locked;
  logic                                       w_cfg_ok;
  logic                                       w_cfg_bad;

  // Credit uses registered counts only; a pop this cycle frees its slot next cycle.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_occ};
  assign w_credit_ok  = w_credit_sum < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_accept = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(r_last) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_accept && bus.req_vld[idx] && w_credit_ok && reset_n) begin
        w_accept     = 1'b1;
        w_grant[idx] = 1'b1;
        w_gnt_id     = ID_W'(idx);
      end
    end
  end

  assign w_tail_vld = r_tag_vld[KLAT-1];
  assign w_tail_id  = r_tag_id[KLAT-1];
  assign w_push     = w_tail_vld && bus.k_dout_vld;
  assign w_res_vld  = (r_occ != '0);
  assign w_pop      = w_res_vld && bus.res_rdy;

  assign w_cfg_in_range = (int'(bus.cfg_id) < NUM_REQ) && (int'(bus.cfg_tap) < KERN_SIZE);

`ifdef CONV_ARB_COEF_LOCK_EN
  logic [CNT_W-1:0] r_req_cnt [NUM_REQ];

  assign w_cfg_locked = w_cfg_in_range && (r_req_cnt[bus.cfg_id] != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_req_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((w_accept && w_gnt_id == ID_W'(i)) && !(w_tail_vld && w_tail_id == ID_W'(i)))
          r_req_cnt[i] <= r_req_cnt[i] + CNT_W'(1);
        else if (!(w_accept && w_gnt_id == ID_W'(i)) && (w_tail_vld && w_tail_id == ID_W'(i)))
          r_req_cnt[i] <= r_req_cnt[i] - CNT_W'(1);
      end
    end
  end
`else
  assign w_cfg_locked = 1'b0;
`endif

  assign w_cfg_ok  = bus.cfg_we && w_cfg_in_range && !w_cfg_locked;
  assign w_cfg_bad = bus.cfg_we && !w_cfg_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank    <= '0;
      r_cfg_ack <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_ack <= w_cfg_ok;
      r_cfg_err <= w_cfg_bad;
      if (w_cfg_ok) r_bank[bus.cfg_id][bus.cfg_tap] <= bus.cfg_coef;
    end
  end

  // Issue register samples the bank before any same-edge cfg write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= ID_W'(NUM_REQ - 1);
      r_k_din_vld <= 1'b0;
      r_k_din     <= '0;
      r_k_kernel  <= '0;
      r_issue_id  <= '0;
    end else begin
      r_k_din_vld <= w_accept;
      if (w_accept) begin
        r_last     <= w_gnt_id;
        r_k_din    <= bus.req_din[w_gnt_id];
        r_k_kernel <= r_bank[w_gnt_id];
        r_issue_id <= w_gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld    <= '0;
      for (int s = 0; s < KLAT; s++) r_tag_id[s] <= '0;
      r_inflight   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_tag_vld[0] <= r_k_din_vld;
      r_tag_id[0]  <= r_issue_id;
      for (int s = 1; s < KLAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (w_accept && !w_tail_vld)
        r_inflight <= r_inflight + CNT_W'(1);
      else if (!w_accept && w_tail_vld)
        r_inflight <= r_inflight - CNT_W'(1);
      if (bus.k_dout_vld && !w_tail_vld) r_err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= w_tail_id;
      r_mem_dout[r_wr_ptr] <= bus.k_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_occ <= r_occ + CNT_W'(1);
      else if (w_pop && !w_push)
        r_occ <= r_occ - CNT_W'(1);
    end
  end

  assign bus.req_rdy    = w_grant;
  assign bus.cfg_ack    = r_cfg_ack;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.k_din_vld  = r_k_din_vld;
  assign bus.k_din      = r_k_din;
  assign bus.k_kernel   = r_k_kernel;
  assign bus.res_vld    = w_res_vld;
  assign bus.res_id     = w_res_vld ? r_mem_id[r_rd_ptr]   : '0;
  assign bus.res_dout   = w_res_vld ? r_mem_dout[r_rd_ptr] : '0;
  assign bus.err_orphan = r_err_orphan;
endmodule

// File: tb/tb_conv_kernel_arbiter.sv
// Directed bench for conv_kernel_arbiter with a 3-cycle stub kernel that sums the window taps.
module tb_conv_kernel_arbiter;
  logic clk;
  logic resetN;
  logic forceVld;
  int   checkCount;
  int   passCount;
  int   grantIds[$];
  int   grantCycles[$];
  int   resIds[$];
  int   resDouts[$];
  int   grantNum;

  logic [2:0] stubVld;
  logic [7:0] stubSum [3];

  conv_kernel_arbiter_if bus ();

  conv_kernel_arbiter dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub kernel: three register stages so k_dout_vld trails k_din_vld by three cycles.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stubVld <= '0;
      for (int i = 0; i < 3; i++) stubSum[i] <= '0;
    end else begin
      stubVld    <= {stubVld[1:0], bus.k_din_vld};
      stubSum[0] <= bus.k_din[0] + bus.k_din[1] + bus.k_din[2];
      stubSum[1] <= stubSum[0];
      stubSum[2] <= stubSum[1];
    end
  end

  assign bus.k_dout_vld = stubVld[2] | forceVld;
  assign bus.k_dout     = stubSum[2];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickCollect();
    if (bus.res_vld && bus.res_rdy) begin
      resIds.push_back(int'(bus.res_id));
      resDouts.push_back(int'(bus.res_dout));
    end
    tick();
  endtask

  task automatic applyStimulus(input logic [3:0] vld, input logic rdy);
    bus.req_vld = vld;
    bus.res_rdy = rdy;
    #1;
  endtask

  task automatic setWindow(input int id, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    bus.req_din[id][0] = t0;
    bus.req_din[id][1] = t1;
    bus.req_din[id][2] = t2;
  endtask

  task automatic setCfg(input logic we, input logic [1:0] id, input logic [1:0] tap, input logic [15:0] coef);
    bus.cfg_we   = we;
    bus.cfg_id   = id;
    bus.cfg_tap  = tap;
    bus.cfg_coef = coef;
  endtask

  function automatic int grantIndex(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    forceVld   = 1'b0;
    resetN     = 1'b0;
    bus.req_din = '0;
    setCfg(1'b0, 2'd0, 2'd0, 16'h0);
    applyStimulus(4'b1111, 1'b1);
    repeat (3) tick();

    checkOutput("reset_req_rdy",    bus.req_rdy,    0);
    checkOutput("reset_k_din_vld",  bus.k_din_vld,  0);
    checkOutput("reset_res_vld",    bus.res_vld,    0);
    checkOutput("reset_cfg_ack",    bus.cfg_ack,    0);
    checkOutput("reset_err_orphan", bus.err_orphan, 0);
    resetN = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    tick();

    // Single requester: accept at T, k_din_vld at T+1, result at T+5.
    setWindow(2, 8'd1, 8'd2, 8'd3);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_grant", bus.req_rdy, 4'b0100);
    tick();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_k_din_vld", bus.k_din_vld, 1);
    checkOutput("single_k_din",     bus.k_din,     24'h030201);
    checkOutput("single_k_kernel",  bus.k_kernel,  0);
    tick();
    checkOutput("single_k_din_vld_drop", bus.k_din_vld, 0);
    tick();
    tick();
    checkOutput("single_res_early", bus.res_vld, 0);
    tick();
    checkOutput("single_res_vld",  bus.res_vld,  1);
    checkOutput("single_res_id",   bus.res_id,   2);
    checkOutput("single_res_dout", bus.res_dout, 6);
    tick();
    checkOutput("single_res_popped", bus.res_vld, 0);

    // Out-of-range tap is rejected.
    setCfg(1'b1, 2'd1, 2'd3, 16'h1234);
    tick();
    setCfg(1'b0, 2'd0, 2'd0, 16'h0);
    checkOutput("badtap_err", bus.cfg_err, 1);
    checkOutput("badtap_ack", bus.cfg_ack, 0);
    tick();
    checkOutput("badtap_err_pulse", bus.cfg_err, 0);

    // Coefficient write to requester 1 while its window is in flight.
    setWindow(1, 8'd5, 8'd5, 8'd5);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("load_grant", bus.req_rdy, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1);
    setCfg(1'b1, 2'd1, 2'd0, 16'h0100);
    tick();
    setCfg(1'b0, 2'd0, 2'd0, 16'h0);
`ifdef CONV_ARB_COEF_LOCK_EN
    checkOutput("load_cfg_err", bus.cfg_err, 1);
    checkOutput("load_cfg_ack", bus.cfg_ack, 0);
`else
    checkOutput("load_cfg_ack", bus.cfg_ack, 1);
    checkOutput("load_cfg_err", bus.cfg_err, 0);
`endif
    repeat (8) tick();

    // Next requester-1 issue, with a same-cycle write to tap 1 that must not be seen yet.
    applyStimulus(4'b0010, 1'b1);
    setCfg(1'b1, 2'd1, 2'd1, 16'h0200);
    checkOutput("reissue_grant", bus.req_rdy, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1);
    setCfg(1'b0, 2'd0, 2'd0, 16'h0);
`ifdef CONV_ARB_COEF_LOCK_EN
    checkOutput("reissue_k_kernel", bus.k_kernel, 48'h0000_0000_0000);
`else
    checkOutput("reissue_k_kernel", bus.k_kernel, 48'h0000_0000_0100);
`endif
    repeat (8) tick();
    applyStimulus(4'b0010, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
`ifdef CONV_ARB_COEF_LOCK_EN
    checkOutput("third_k_kernel", bus.k_kernel, 48'h0000_0200_0000);
`else
    checkOutput("third_k_kernel", bus.k_kernel, 48'h0000_0200_0100);
`endif
    repeat (8) tick();

    // Orphan result: forced kernel valid with nothing in flight.
    forceVld = 1'b1;
    tick();
    forceVld = 1'b0;
    checkOutput("orphan_flag",    bus.err_orphan, 1);
    checkOutput("orphan_res_vld", bus.res_vld,    0);
    repeat (3) tick();
    checkOutput("orphan_sticky",  bus.err_orphan, 1);
    checkOutput("orphan_res_vld_late", bus.res_vld, 0);

    // Round-robin with all requesters valid; last grant was 1, so order starts at 2.
    for (int i = 0; i < 4; i++) setWindow(i, 8'(i + 1), 8'd0, 8'd0);
    resIds.delete();
    resDouts.delete();
    applyStimulus(4'b1111, 1'b1);
    for (int c = 0; c < 12; c++) begin
      checkOutput("rr_onehot", {63'd0, $onehot0(bus.req_rdy)}, 1);
      if (bus.req_rdy != 4'b0000) begin
        grantIds.push_back(grantIndex(bus.req_rdy));
        grantCycles.push_back(c);
      end
      tickCollect();
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (10) tickCollect();
    checkOutput("rr_grant_count", grantIds.size(), 8);
    checkOutput("rr_result_count", resIds.size(), 8);
    if (grantCycles.size() > 4) checkOutput("rr_credit_gap", grantCycles[4], 6);
    for (int k = 0; k < 8; k++) begin
      if (k < grantIds.size()) checkOutput("rr_grant_order", grantIds[k], (2 + k) % 4);
      if (k < resIds.size()) begin
        checkOutput("rr_res_id",   resIds[k],   (2 + k) % 4);
        checkOutput("rr_res_dout", resDouts[k], ((2 + k) % 4) + 1);
      end
    end

    // Backpressure: four acceptances fill the credit, then nothing.
    grantNum = 0;
    applyStimulus(4'b1111, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (bus.req_rdy != 4'b0000) grantNum++;
      tick();
    end
    checkOutput("bp_grant_count", grantNum, 4);
    checkOutput("bp_stalled",     bus.req_rdy, 0);
    checkOutput("bp_res_vld",     bus.res_vld, 1);
    applyStimulus(4'b1111, 1'b1);
    checkOutput("bp_no_same_cycle_credit", bus.req_rdy, 0);
    tick();
    applyStimulus(4'b1111, 1'b0);
    checkOutput("bp_one_grant", bus.req_rdy, 4'b0100);
    tick();
    checkOutput("bp_stalled_again", bus.req_rdy, 0);
    tick();
    checkOutput("bp_stalled_hold", bus.req_rdy, 0);

    // Reset with results queued and a window in flight.
    resetN = 1'b0;
    #1;
    checkOutput("midreset_req_rdy",    bus.req_rdy,    0);
    checkOutput("midreset_res_vld",    bus.res_vld,    0);
    checkOutput("midreset_res_id",     bus.res_id,     0);
    checkOutput("midreset_res_dout",   bus.res_dout,   0);
    checkOutput("midreset_k_din_vld",  bus.k_din_vld,  0);
    checkOutput("midreset_k_din",      bus.k_din,      0);
    checkOutput("midreset_k_kernel",   bus.k_kernel,   0);
    checkOutput("midreset_err_orphan", bus.err_orphan, 0);
    tick();
    resetN = 1'b1;
    resIds.delete();
    resDouts.delete();
    applyStimulus(4'b1111, 1'b1);
    checkOutput("postreset_grant", bus.req_rdy, 4'b0001);
    tickCollect();
    applyStimulus(4'b0000, 1'b1);
    repeat (10) tickCollect();
    checkOutput("postreset_result_count", resIds.size(), 1);
    if (resIds.size() > 0) begin
      checkOutput("postreset_res_id",   resIds[0],   0);
      checkOutput("postreset_res_dout", resDouts[0], 1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
